sram_like_arbiter: RTL and testbench

Shares one sram-like request port (downstream, toward the AXI bridge) between the instruction-fetch requester and the data-access requester. It arbitrates requests with fixed data-over-inst priority, holds a grant stable until the address handshake completes, and tracks outstanding requests in a tag FIFO. Each data_ok/rdata response is routed back to the requester that issued it, in request order. It sits between the IF/EXE stage sram-like ports and the single-master side of the AXI bridge.

---
 rtl/sram_like_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like downstream port between the
// instruction-fetch and data-access requesters. Data has fixed priority over
// inst, a presented request keeps its grant until accepted, and a tag FIFO
// routes each in-order response back to the requester that issued it.
// Optional build macro: ARB_STARVE_GUARD_EN forces an inst grant after
// STARVE_LIMIT consecutive data accepts while inst is waiting.
module sram_like_arbiter #(
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

    typedef enum logic {
        SEL_INST = 1'b0,
        SEL_DATA = 1'b1
    } sel_t;

    sel_t pick;
    sel_t sel;
    sel_t lock_sel;
    sel_t head;
    logic lock_valid;

    logic [MAX_OUTST-1:0] tags;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic full;
    logic sel_req;
    logic accept;
    logic pop;

    // Marker block appears in the elaborated hierarchy only when the
    // parameter set is outside the supported range (depth power of two >= 2,
    // starvation limit >= 1).
    if (MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

    logic [SCNT_W-1:0] starve_cnt;

    // Count data accepts that overtook a waiting inst request, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!inst_req) begin
            starve_cnt <= '0;
        end else if (accept && sel == SEL_INST) begin
            starve_cnt <= '0;
        end else if (accept && sel == SEL_DATA && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SCNT_W'(1);
        end
    end

    // Data-over-inst priority, overridden once inst has been passed over too often.
    always_comb begin
        pick = SEL_INST;
        if (data_req) begin
            pick = SEL_DATA;
        end
        if (starve_cnt == STARVE_MAX && !lock_valid && inst_req) begin
            pick = SEL_INST;
        end
    end
`else
    // Pure data-over-inst priority.
    always_comb begin
        pick = SEL_INST;
        if (data_req) begin
            pick = SEL_DATA;
        end
    end
`endif

    // Grant selection and downstream request mux; a locked grant wins over pick.
    always_comb begin
        sel        = lock_valid ? lock_sel : pick;
        sel_req    = inst_req;
        mem_wr     = inst_wr;
        mem_size   = inst_size;
        mem_wstrb  = inst_wstrb;
        mem_addr   = inst_addr;
        mem_wdata  = inst_wdata;
        if (sel == SEL_DATA) begin
            sel_req   = data_req;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    assign full    = (count == FULL_CNT);
    assign mem_req = sel_req && !full;
    assign accept  = mem_req && mem_addr_ok;
    // A response with nothing outstanding (e.g. after reset) is dropped.
    assign pop     = mem_data_ok && (count != '0);
    assign head    = tags[rd_ptr] ? SEL_DATA : SEL_INST;

    assign inst_addr_ok = accept && (sel == SEL_INST);
    assign data_addr_ok = accept && (sel == SEL_DATA);
    assign inst_data_ok = pop && (head == SEL_INST);
    assign data_data_ok = pop && (head == SEL_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Hold the grant while a presented request waits for mem_addr_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_sel   <= SEL_INST;
        end else if (mem_req) begin
            lock_valid <= !mem_addr_ok;
            lock_sel   <= sel;
        end
    end

    // Tag FIFO pointers and occupancy; push on accept, pop on a routed response.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Tag storage: records which requester owns each outstanding request.
    always_ff @(posedge clk) begin
        if (accept) begin
            tags[wr_ptr] <= (sel == SEL_DATA);
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed testbench for sram_like_arbiter (default MAX_OUTST=4, STARVE_LIMIT=3).
// Inputs are driven 1 time unit after the rising edge, outputs are checked
// 2 time units after the rising edge.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    sram_like_arbiter #(.MAX_OUTST(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before checking.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    logic exp_d, exp_i;

    initial begin
        idle_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
        settle();
        check("rst_mem_req", {31'b0, mem_req}, 0);
        check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 0);
        check("rst_data_addr_ok", {31'b0, data_addr_ok}, 0);
        check("rst_inst_data_ok", {31'b0, inst_data_ok}, 0);
        check("rst_data_data_ok", {31'b0, data_data_ok}, 0);

        // Stray response with nothing outstanding is dropped.
        next_cycle();
        mem_data_ok = 1; mem_rdata = 32'hdeadbeef;
        settle();
        check("empty_inst_data_ok", {31'b0, inst_data_ok}, 0);
        check("empty_data_data_ok", {31'b0, data_data_ok}, 0);
        check("rdata_passthru", inst_rdata, 32'hdeadbeef);

        // Single inst read.
        next_cycle();
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        settle();
        check("t1_mem_req", {31'b0, mem_req}, 1);
        check("t1_mem_addr", mem_addr, 32'h1c000000);
        check("t1_mem_wr", {31'b0, mem_wr}, 0);
        check("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 1);
        check("t1_data_addr_ok", {31'b0, data_addr_ok}, 0);
        next_cycle();
        idle_inputs();
        settle();
        check("t1_wait_inst_data_ok", {31'b0, inst_data_ok}, 0);
        next_cycle();
        mem_data_ok = 1; mem_rdata = 32'h02800404;
        settle();
        check("t1_inst_data_ok", {31'b0, inst_data_ok}, 1);
        check("t1_inst_rdata", inst_rdata, 32'h02800404);
        check("t1_data_data_ok", {31'b0, data_data_ok}, 0);

        // Simultaneous requests: data write wins, inst follows.
        next_cycle();
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1c000004;
        data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h1c001000; data_wdata = 32'h12345678;
        mem_addr_ok = 1;
        settle();
        check("t2_mem_wr", {31'b0, mem_wr}, 1);
        check("t2_mem_addr", mem_addr, 32'h1c001000);
        check("t2_mem_wstrb", {28'b0, mem_wstrb}, 32'hf);
        check("t2_mem_wdata", mem_wdata, 32'h12345678);
        check("t2_data_addr_ok", {31'b0, data_addr_ok}, 1);
        check("t2_inst_addr_ok", {31'b0, inst_addr_ok}, 0);
        next_cycle();
        data_req = 0;
        settle();
        check("t2_mem_addr_inst", mem_addr, 32'h1c000004);
        check("t2_inst_addr_ok2", {31'b0, inst_addr_ok}, 1);
        next_cycle();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000aaaa;
        settle();
        check("t2_resp1_data", {31'b0, data_data_ok}, 1);
        check("t2_resp1_inst", {31'b0, inst_data_ok}, 0);
        next_cycle();
        mem_rdata = 32'h0000bbbb;
        settle();
        check("t2_resp2_inst", {31'b0, inst_data_ok}, 1);
        check("t2_resp2_data", {31'b0, data_data_ok}, 0);

        // Grant lock: inst waits 3 cycles for mem_addr_ok while data arrives.
        next_cycle();
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1c000008;
        settle();
        check("t3_c0_mem_addr", mem_addr, 32'h1c000008);
        check("t3_c0_mem_req", {31'b0, mem_req}, 1);
        next_cycle();
        data_req = 1; data_addr = 32'h1c002000;
        settle();
        check("t3_c1_mem_addr", mem_addr, 32'h1c000008);
        check("t3_c1_data_addr_ok", {31'b0, data_addr_ok}, 0);
        next_cycle();
        settle();
        check("t3_c2_mem_addr", mem_addr, 32'h1c000008);
        next_cycle();
        mem_addr_ok = 1;
        settle();
        check("t3_c3_mem_addr", mem_addr, 32'h1c000008);
        check("t3_c3_inst_addr_ok", {31'b0, inst_addr_ok}, 1);
        check("t3_c3_data_addr_ok", {31'b0, data_addr_ok}, 0);
        next_cycle();
        inst_req = 0;
        settle();
        check("t3_c4_mem_addr", mem_addr, 32'h1c002000);
        check("t3_c4_data_addr_ok", {31'b0, data_addr_ok}, 1);
        next_cycle();
        idle_inputs();
        mem_data_ok = 1;
        settle();
        check("t3_resp1_inst", {31'b0, inst_data_ok}, 1);
        next_cycle();
        settle();
        check("t3_resp2_data", {31'b0, data_data_ok}, 1);
        check("t3_resp2_inst", {31'b0, inst_data_ok}, 0);

        // Full FIFO behaviour.
        next_cycle();
        idle_inputs();
        data_req = 1; data_addr = 32'h1c003000; mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t4_fill%0d_addr_ok", i), {31'b0, data_addr_ok}, 1);
            next_cycle();
        end
        settle();
        check("t4_full_mem_req", {31'b0, mem_req}, 0);
        check("t4_full_addr_ok", {31'b0, data_addr_ok}, 0);
        next_cycle();
        mem_data_ok = 1;
        settle();
        check("t4_pop_still_full", {31'b0, mem_req}, 0);
        check("t4_pop_data_ok", {31'b0, data_data_ok}, 1);
        next_cycle();
        mem_data_ok = 0;
        settle();
        check("t4_reassert_mem_req", {31'b0, mem_req}, 1);
        check("t4_reassert_addr_ok", {31'b0, data_addr_ok}, 1);
        next_cycle();
        settle();
        check("t4_refull_mem_req", {31'b0, mem_req}, 0);
        next_cycle();
        mem_data_ok = 1;
        settle();
        check("t4_pop2_mem_req", {31'b0, mem_req}, 0);
        next_cycle();
        settle();
        check("t4_pushpop_addr_ok", {31'b0, data_addr_ok}, 1);
        check("t4_pushpop_data_ok", {31'b0, data_data_ok}, 1);
        next_cycle();
        mem_data_ok = 0;
        settle();
        check("t4_push_to_full", {31'b0, data_addr_ok}, 1);
        next_cycle();
        settle();
        check("t4_full_again", {31'b0, mem_req}, 0);
        next_cycle();
        data_req = 0; mem_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t4_drain%0d", i), {31'b0, data_data_ok}, 1);
            next_cycle();
        end
        settle();
        check("t4_drained_extra", {31'b0, data_data_ok}, 0);

        // Reset with two outstanding inst requests and a held lock.
        next_cycle();
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1c000010; mem_addr_ok = 1;
        next_cycle();
        next_cycle();
        mem_addr_ok = 0;
        next_cycle();
        idle_inputs();
        reset = 1;
        next_cycle();
        reset = 0;
        mem_data_ok = 1;
        settle();
        check("t5_late1_inst", {31'b0, inst_data_ok}, 0);
        check("t5_late1_data", {31'b0, data_data_ok}, 0);
        next_cycle();
        settle();
        check("t5_late2_inst", {31'b0, inst_data_ok}, 0);
        check("t5_late2_data", {31'b0, data_data_ok}, 0);
        next_cycle();
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1c000014; data_req = 1; data_addr = 32'h1c004000; mem_addr_ok = 1;
        settle();
        check("t5_lock_cleared", {31'b0, data_addr_ok}, 1);
        next_cycle();
        data_req = 0;
        settle();
        check("t5_inst_after", {31'b0, inst_addr_ok}, 1);
        next_cycle();
        idle_inputs();
        mem_data_ok = 1;
        settle();
        check("t5_resp_data_first", {31'b0, data_data_ok}, 1);
        next_cycle();
        settle();
        check("t5_resp_inst_second", {31'b0, inst_data_ok}, 1);

        // Both requesters held high continuously.
        next_cycle();
        idle_inputs();
        next_cycle();
        inst_req = 1; inst_addr = 32'h1c000020; data_req = 1; data_addr = 32'h1c005000; mem_addr_ok = 1;
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_i = (i % 4) == 3;
`else
            exp_i = 1'b0;
`endif
            exp_d = !exp_i;
            settle();
            check($sformatf("t6_g%0d_data", i), {31'b0, data_addr_ok}, {31'b0, exp_d});
            check($sformatf("t6_g%0d_inst", i), {31'b0, inst_addr_ok}, {31'b0, exp_i});
            next_cycle();
            mem_data_ok = 1;
        end
        idle_inputs();
        mem_data_ok = 1;
        next_cycle();
        idle_inputs();
        settle();
        check("t6_end_idle", {31'b0, mem_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
